// File: rtl/seq_mul_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : seq_mul_unit                                                   |
// | Brief    : Shift-add multiplier, one multiplier bit per clock, with       |
// |            bus-loaded A/B registers. Define SIGNED_MUL_EN for signed ops. |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module seq_mul_unit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_n,
  input  logic                 a_or_b,
  input  logic                 set_n,
  input  logic [WIDTH-1:0]     curr_in,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 done
);

  localparam int              c_PW   = 2 * WIDTH;
  localparam int              c_CW   = $clog2(WIDTH);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic             r_load_n_q;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [c_PW-1:0]  r_mcand;
  logic [WIDTH-1:0] r_mplr;
  logic [c_PW-1:0]  r_acc;
  logic [c_CW-1:0]  r_cnt;

  logic             w_start;
  logic             w_wr;
  logic             w_go;
  logic             w_last;
  logic [WIDTH-1:0] w_a_eff;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [c_PW-1:0]  w_acc_sum;
  logic [c_PW-1:0]  w_prod;

  assign w_start = r_load_n_q & ~load_n;
  assign w_wr    = ~set_n & (r_state != c_BUSY);
  assign w_go    = w_start & (r_state != c_BUSY);
  assign w_last  = (r_state == c_BUSY) && (r_cnt == c_LAST);

  // A write coinciding with a start must feed the new operand into the multiply
  assign w_a_eff = (w_wr & ~a_or_b) ? curr_in : r_a;
  assign w_b_eff = (w_wr &  a_or_b) ? curr_in : r_b;

  assign w_acc_sum = r_acc + (r_mplr[0] ? r_mcand : '0);

`ifdef SIGNED_MUL_EN
  logic r_sign;

  // Negating the most-negative value yields 2^(WIDTH-1), correct as unsigned
  assign w_a_mag = w_a_eff[WIDTH-1] ? (~w_a_eff + WIDTH'(1)) : w_a_eff;
  assign w_b_mag = w_b_eff[WIDTH-1] ? (~w_b_eff + WIDTH'(1)) : w_b_eff;
  assign w_prod  = r_sign ? (~w_acc_sum + c_PW'(1)) : w_acc_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign <= 1'b0;
    end else if (w_go) begin
      r_sign <= w_a_eff[WIDTH-1] ^ w_b_eff[WIDTH-1];
    end
  end
`else
  assign w_a_mag = w_a_eff;
  assign w_b_mag = w_b_eff;
  assign w_prod  = w_acc_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (w_start) w_state_next = c_BUSY;
      c_BUSY:  if (w_last)  w_state_next = c_DONE;
      c_DONE:  if (w_start) w_state_next = c_BUSY;
      default: w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == c_BUSY);
    done = (r_state == c_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_n_q <= 1'b1;
    end else begin
      r_load_n_q <= load_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      result  <= '0;
    end else begin
      if (w_wr) begin
        if (a_or_b) r_b <= curr_in;
        else        r_a <= curr_in;
      end
      if (w_go) begin
        r_mcand <= {{WIDTH{1'b0}}, w_a_mag};
        r_mplr  <= w_b_mag;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (r_state == c_BUSY) begin
        r_acc   <= w_acc_sum;
        r_mcand <= r_mcand << 1;
        r_mplr  <= r_mplr >> 1;
        r_cnt   <= r_cnt + c_CW'(1);
        if (w_last) result <= w_prod;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_seq_mul_unit                                                |
// | Brief    : Directed + random bench for seq_mul_unit against a product     |
// |            model (signed when SIGNED_MUL_EN is defined).                  |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module tb_seq_mul_unit;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           load_n;
  logic           a_or_b;
  logic           set_n;
  logic [W-1:0]   curr_in;
  logic [2*W-1:0] result;
  logic           busy;
  logic           done;

  int             tests = 0;
  int             fails = 0;
  logic [W-1:0]   ma = '0;
  logic [W-1:0]   mb = '0;
  logic [2*W-1:0] exp_res = '0;

  always #5 clk = ~clk;

  seq_mul_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .load_n  (load_n),
    .a_or_b  (a_or_b),
    .set_n   (set_n),
    .curr_in (curr_in),
    .result  (result),
    .busy    (busy),
    .done    (done)
  );

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SIGNED_MUL_EN
    int sa, sb, p;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    return p[2*W-1:0];
`else
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return p;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_op(input logic sel, input logic [W-1:0] v);
    set_n = 1'b0; a_or_b = sel; curr_in = v;
    tick;
    set_n = 1'b1;
    if (sel) mb = v; else ma = v;
  endtask

  // Falling edge on load_n, optionally with an operand write in the same cycle
  task automatic launch(input bit wr, input logic sel, input logic [W-1:0] v);
    load_n = 1'b1;
    tick;
    load_n = 1'b0;
    if (wr) begin
      set_n = 1'b0; a_or_b = sel; curr_in = v;
    end
    tick;
    set_n = 1'b1;
    if (wr) begin
      if (sel) mb = v; else ma = v;
    end
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_old_result", result, exp_res);
  endtask

  task automatic finish(input string tag, input bit busy_wr);
    int n;
    n = 0;
    while (n < 3 * W) begin
      if (busy_wr) begin
        set_n = 1'b0; a_or_b = n[0]; curr_in = W'($urandom);
      end
      tick;
      n++;
      if (done) break;
      if (n == W / 2) chk({tag, "_mid_hold"}, result, exp_res);
    end
    set_n = 1'b1;
    exp_res = ref_mul(ma, mb);
    chk({tag, "_latency"}, n, W);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 1);
  endtask

  initial begin
    rst = 1'b1; load_n = 1'b1; set_n = 1'b1; a_or_b = 1'b0; curr_in = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    write_op(1'b0, 8'd20);
    write_op(1'b1, 8'd23);
    launch(1'b0, 1'b0, '0);
    finish("t1", 1'b0);
    chk("t1_const", result, 16'h01CC);

    // load_n held low: no retrigger
    for (int i = 0; i < 40; i++) begin
      tick;
      chk("hold_done", done, 1);
      chk("hold_busy", busy, 0);
    end
    chk("hold_result", result, exp_res);

    // writes during BUSY are dropped; rerun proves A/B kept
    write_op(1'b0, 8'd3);
    write_op(1'b1, 8'd5);
    launch(1'b0, 1'b0, '0);
    finish("busy_wr", 1'b1);
    launch(1'b0, 1'b0, '0);
    finish("rerun", 1'b0);

    write_op(1'b0, 8'hFF);
    write_op(1'b1, 8'hFF);
    launch(1'b0, 1'b0, '0);
    finish("ff_ff", 1'b0);
    write_op(1'b0, 8'h00);
    launch(1'b0, 1'b0, '0);
    finish("zero_a", 1'b0);
    chk("zero_a_const", result, 16'h0000);

    write_op(1'b0, 8'hFD);
    write_op(1'b1, 8'h05);
    launch(1'b0, 1'b0, '0);
    finish("fd_5", 1'b0);
`ifdef SIGNED_MUL_EN
    chk("fd_5_const", result, 16'hFFF1);
`else
    chk("fd_5_const", result, 16'h04F1);
`endif

    write_op(1'b0, 8'h80);
    write_op(1'b1, 8'h80);
    launch(1'b0, 1'b0, '0);
    finish("neg_max", 1'b0);
    chk("neg_max_const", result, 16'h4000);

    write_op(1'b1, 8'd3);
    launch(1'b1, 1'b0, 8'd7);
    finish("same_cycle", 1'b0);
    chk("same_cycle_const", result, 16'h0015);

    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      write_op(1'b0, ra);
      write_op(1'b1, rb);
      launch(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), W'($urandom));
      finish("rand", ($urandom_range(0, 1) == 1));
    end

    // reset in the middle of a multiply
    write_op(1'b0, 8'd20);
    write_op(1'b1, 8'd23);
    launch(1'b0, 1'b0, '0);
    tick;
    tick;
    tick;
    rst = 1'b1; load_n = 1'b1;
    tick;
    rst = 1'b0;
    ma = '0; mb = '0; exp_res = '0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    launch(1'b0, 1'b0, '0);
    finish("after_rst", 1'b0);
    chk("after_rst_const", result, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
